// File: rtl/reg_bank.sv
// reg_bank: four 8-bit registers (A..D) with LOAD/INC/DEC commands, zero and
// carry/borrow flags, and a multi-cycle CLR_ALL sequence that clears one
// register per clock while busy is high.
// Optional build macro: REG_BANK_SAT_EN makes INC/DEC saturate at 0xFF/0x00
// instead of wrapping modulo 256.
module reg_bank #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] Aout,
  output logic [DATA_W-1:0] Bout,
  output logic [DATA_W-1:0] Cout,
  output logic [DATA_W-1:0] Dout,
  output logic              zf,
  output logic              cf,
  output logic              busy
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;
  logic              accept;
  logic [DATA_W:0]   inc_res;
  logic [DATA_W:0]   dec_res;

  // Increment returning {carry, result}; the carry marks an old value of all-ones.
  function automatic logic [DATA_W:0] inc_val(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] r;
`ifdef REG_BANK_SAT_EN
    if (&v) r = {1'b1, v};
    else    r = {1'b0, v + {{(DATA_W-1){1'b0}}, 1'b1}};
`else
    r = {1'b0, v} + {{DATA_W{1'b0}}, 1'b1};
`endif
    return r;
  endfunction

  // Decrement returning {borrow, result}; the borrow marks an old value of zero.
  function automatic logic [DATA_W:0] dec_val(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] r;
`ifdef REG_BANK_SAT_EN
    if (v == '0) r = {1'b1, v};
    else         r = {1'b0, v - {{(DATA_W-1){1'b0}}, 1'b1}};
`else
    r = {(v == '0), v - {{(DATA_W-1){1'b0}}, 1'b1}};
`endif
    return r;
  endfunction

  // Commands are only taken while no clear sequence is running.
  assign accept  = en && (state_q == IDLE);
  assign inc_res = inc_val(regs_q[sel]);
  assign dec_res = dec_val(regs_q[sel]);

  // Sequence controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: CLR walks the index 0..3, one register per edge, then
  // returns to IDLE on the edge that clears D (index wraps back to 0).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept && (op == OP_CLR)) begin
          state_d = CLR;
          idx_d   = 2'd0;
        end
      end
      CLR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Datapath next values: clear step while sequencing, otherwise the accepted
  // command; NOP, CLR_ALL start and reserved codes leave everything as is.
  always_comb begin
    regs_d = regs_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    if (state_q == CLR) begin
      regs_d[idx_q] = '0;
      if (idx_q == 2'd3) begin
        zf_d = 1'b1;
        cf_d = 1'b0;
      end
    end else if (accept) begin
      case (op)
        OP_LOAD: begin
          regs_d[sel] = din;
          zf_d        = (din == '0);
          cf_d        = 1'b0;
        end
        OP_INC: begin
          regs_d[sel] = inc_res[DATA_W-1:0];
          zf_d        = (inc_res[DATA_W-1:0] == '0);
          cf_d        = inc_res[DATA_W];
        end
        OP_DEC: begin
          regs_d[sel] = dec_res[DATA_W-1:0];
          zf_d        = (dec_res[DATA_W-1:0] == '0);
          cf_d        = dec_res[DATA_W];
        end
        default: begin
          regs_d = regs_q;
        end
      endcase
    end
  end

  // Register file and flags; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      zf_q <= zf_d;
      cf_q <= cf_d;
    end
  end

  assign Aout = regs_q[0];
  assign Bout = regs_q[1];
  assign Cout = regs_q[2];
  assign Dout = regs_q[3];
  assign zf   = zf_q;
  assign cf   = cf_q;
  assign busy = (state_q == CLR);

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard bench for reg_bank. A driver issues one command per
// cycle and pushes the expected post-edge outputs from a behavioural model;
// a monitor pops and compares shortly after each rising edge.
// Honours REG_BANK_SAT_EN the same way as the design.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] op  = 3'b000;
  logic [1:0] sel = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] Aout, Bout, Cout, Dout;
  logic       zf, cf, busy;

  typedef struct packed {
    logic [7:0] a, b, c, d;
    logic       zf, cf, busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // behavioural model state
  int m_reg[4];
  int m_zf, m_cf;
  int m_clr;   // 0 = not clearing, k = edge k of the clear is next (1..4)

  reg_bank dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .sel(sel), .din(din),
    .Aout(Aout), .Bout(Bout), .Cout(Cout), .Dout(Dout),
    .zf(zf), .cf(cf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_zf = 0; m_cf = 0; m_clr = 0;
  endtask

  // One rising edge of the reference behaviour, from the command rules.
  task automatic model_edge(input int e, input int o, input int s, input int d);
    int nv;
    if (m_clr != 0) begin
      m_reg[m_clr - 1] = 0;
      if (m_clr == 4) begin m_zf = 1; m_cf = 0; m_clr = 0; end
      else m_clr++;
    end else if (e != 0) begin
      case (o)
        1: begin m_reg[s] = d; m_zf = (d == 0); m_cf = 0; end
        2: begin
          if (m_reg[s] == 255) begin
`ifdef REG_BANK_SAT_EN
            nv = 255;
`else
            nv = 0;
`endif
            m_cf = 1;
          end else begin nv = m_reg[s] + 1; m_cf = 0; end
          m_reg[s] = nv; m_zf = (nv == 0);
        end
        3: begin
          if (m_reg[s] == 0) begin
`ifdef REG_BANK_SAT_EN
            nv = 0;
`else
            nv = 255;
`endif
            m_cf = 1;
          end else begin nv = m_reg[s] - 1; m_cf = 0; end
          m_reg[s] = nv; m_zf = (nv == 0);
        end
        4: m_clr = 1;
        default: ;
      endcase
    end
  endtask

  task automatic do_cmd(input int e, input int o, input int s, input int d);
    exp_t x;
    @(negedge clk);
    en = e[0]; op = o[2:0]; sel = s[1:0]; din = d[7:0];
    model_edge(e, o, s, d);
    x.a = m_reg[0][7:0]; x.b = m_reg[1][7:0]; x.c = m_reg[2][7:0]; x.d = m_reg[3][7:0];
    x.zf = m_zf[0]; x.cf = m_cf[0]; x.busy = (m_clr != 0);
    exp_q.push_back(x);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, Aout, 0); chk({tag, "_B"}, Bout, 0);
    chk({tag, "_C"}, Cout, 0); chk({tag, "_D"}, Dout, 0);
    chk({tag, "_zf"}, zf, 0);  chk({tag, "_cf"}, cf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("A", Aout, e.a); chk("B", Bout, e.b);
        chk("C", Cout, e.c); chk("D", Dout, e.d);
        chk("zf", zf, e.zf); chk("cf", cf, e.cf);
        chk("busy", busy, e.busy);
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Load and read back
    do_cmd(1, 1, 0, 218); do_cmd(1, 1, 1, 235);
    do_cmd(1, 1, 2, 93);  do_cmd(1, 1, 3, 29);
    // INC at 0xFF
    do_cmd(1, 1, 1, 8'hFF); do_cmd(1, 2, 1, 0);
    // DEC at 0x00
    do_cmd(1, 1, 2, 8'h00); do_cmd(1, 3, 2, 0);

    // CLR_ALL timing with a LOAD at N+2 that must be ignored
    do_cmd(1, 1, 0, 1); do_cmd(1, 1, 1, 2); do_cmd(1, 1, 2, 3); do_cmd(1, 1, 3, 4);
    do_cmd(1, 4, 0, 0);     // edge N
    do_cmd(1, 2, 1, 0);     // N+1, ignored
    do_cmd(1, 1, 0, 8'h55); // N+2, ignored
    do_cmd(0, 0, 0, 0);     // N+3
    do_cmd(1, 1, 3, 7);     // N+4, ignored (still busy at this edge)
    do_cmd(1, 1, 2, 9);     // N+5, accepted

    // Reserved opcode leaves everything alone (A=0x10, zf=0, cf=1)
    do_cmd(1, 1, 0, 8'h10);
`ifdef REG_BANK_SAT_EN
    do_cmd(1, 1, 1, 8'hFF); do_cmd(1, 2, 1, 0);
`else
    do_cmd(1, 1, 1, 8'h00); do_cmd(1, 3, 1, 0);
`endif
    do_cmd(1, 6, 0, 8'hAA);
    do_cmd(1, 5, 1, 8'hBB);
    do_cmd(1, 7, 2, 8'hCC);

    // Asynchronous reset between edges N+2 and N+3 of a clear
    do_cmd(1, 1, 3, 8'h44);
    do_cmd(1, 4, 0, 0);  // N
    do_cmd(0, 0, 0, 0);  // N+1
    do_cmd(0, 0, 0, 0);  // N+2
    @(posedge clk);      // N+2 edge
    #3 rst = 1'b1;
    model_reset();
    #1 chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    // first edge with rst low must accept
    do_cmd(1, 1, 0, 8'h5A);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int o;
      o = (($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 7));
      if (o == 4 && $urandom_range(0, 1) == 0) o = 2;
      do_cmd(($urandom_range(0, 4) != 0), o, $urandom_range(0, 3),
             (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                         : $urandom_range(0, 255)));
    end

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
